tt_rng_reader: RTL and testbench
================================

Name: tt_rng_reader

Overview:
Consumer end of the random-bit stream. It accepts the post-processed serial bit stream one bit per qualified cycle and runs two continuous health tests on it: a repetition count test (RCT) and an adaptive proportion test (APT). It packs the bits into words and presents them on a valid/ready interface. It discards output during start-up and after any health failure. It sits between the random-bit source and any word-level consumer, such as the display path or an external host.

Parameters:
WORD_W, 8, output word width in bits (2..16)
RCT_CUTOFF, 16, run length of identical bits that triggers rct_fail (2..255)
APT_WINDOW, 64, APT window length in accepted bits (power of 2, 16..256)
APT_CUTOFF, 48, count of the window's reference value that triggers apt_fail (less than or equal to APT_WINDOW)
STARTUP_WORDS, 4, number of completed words discarded before output is enabled (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
bit_in  in  1  random bit, sampled only when bit_valid=1
bit_valid  in  1  bit_in qualifier, one bit per cycle
word_out  out  WORD_W  packed random word
word_valid  out  1  word_out holds a valid word
word_ready  in  1  consumer accepts word_out this cycle
rct_fail  out  1  sticky RCT failure flag
apt_fail  out  1  sticky APT failure flag
health_ok  out  1  high only in state RUN
clear_fail  in  1  single-cycle request to leave FAIL
drop_cnt  out  8  saturating count of words dropped due to backpressure

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=STARTUP; all outputs 0; bit counter, packing register, RCT/APT counters and start-up counter cleared.
  - A partial word in progress is lost.
- FSM states and transitions:
  - STARTUP -> RUN when the STARTUP_WORDS-th word completes with no failure. Those words are not presented.
  - STARTUP or RUN -> FAIL on any health failure.
  - FAIL -> STARTUP on clear_fail=1. In STARTUP and RUN, clear_fail is ignored.
- Packing:
  - Bits are packed LSB-first: the first accepted bit of a word goes to word_out[0].
  - A word completes on the cycle of its WORD_W-th accepted bit.
  - In RUN, word_valid rises the cycle after completion (latency 1 from the last bit_valid).
- Output handshake:
  - One-entry output buffer.
  - word_out is stable while word_valid=1 and word_ready=0.
  - A transfer occurs when word_valid and word_ready are both 1.
  - If a word completes in the same cycle as a transfer, the new word is loaded and word_valid stays 1.
  - If a word completes while the buffer is full and not being transferred, the new word is discarded and drop_cnt increments, saturating at 255.
- RCT:
  - Tracks the previous bit and a run counter.
  - The first bit after reset or after clear_fail sets run=1.
  - Each later bit equal to the previous bit increments run; a different bit sets run=1.
  - When run reaches RCT_CUTOFF, rct_fail is set.
- APT:
  - The first bit of each window is the reference value and sets count=1.
  - Each later bit in the window equal to the reference increments count.
  - When count reaches APT_CUTOFF, apt_fail is set.
  - After APT_WINDOW bits, the next bit starts a new window. Windows do not overlap.
- Failure handling:
  - Flags are registered and rise the cycle after the offending bit.
  - In the same cycle the flag rises: state=FAIL, word_valid forced to 0, the buffered word flushed (not counted in drop_cnt), and the partial word discarded.
  - Both flags may set in the same cycle.
- In FAIL:
  - Bits are ignored and no tests run. This includes a bit arriving in the same cycle as clear_fail.
  - clear_fail clears rct_fail, apt_fail, the packing state, the RCT/APT counters and the start-up counter. drop_cnt is preserved.
- Word-counter wrap: the bit counter wraps to 0 on each completed word. The APT counter wraps at the window end.

Test Plan:
- Reset with rst_n low mid-word -> word_valid=0, rct_fail=apt_fail=0, health_ok=0, drop_cnt=0. The next word packs from bit 0.
- Feed 40 bits, word_ready=1. Words 0-3 use 0x55 pattern (LSB-first 1,0,1,0...); word 4 bits LSB-first 0,1,0,1,1,0,1,0 -> no word_valid during the first 32 bits. health_ok=1 the cycle after bit 32. word_out=0x5A with word_valid=1 the cycle after bit 40.
- From RUN with word_ready=0, complete 3 words -> the first word is held stable, drop_cnt=2. Raise word_ready for 1 cycle -> transfer occurs, word_valid=0.
- From RUN, feed 15 ones then a 0 -> no fail. Then feed 16 ones -> rct_fail=1 the cycle after the 16th one, health_ok=0, word_valid=0.
- Start a fresh window with reference 0. Feed 48 zeros in groups of 3 separated by single ones, never reaching a run of 16 -> apt_fail=1 the cycle after the 48th zero. Repeat with 47 zeros in the window -> no fail.
- In FAIL, pulse clear_fail together with bit_valid=1 -> flags clear next cycle, state=STARTUP, drop_cnt unchanged. The bit is ignored, and the next 32 accepted bits are discarded before health_ok=1.

Source files
------------

// File: rtl/tt_rng_reader.sv
// tt_rng_reader: consumer end of the random-bit stream.
// Runs a repetition count test and an adaptive proportion test on each accepted bit.
// Packs accepted bits LSB-first into words and offers them on a one-entry valid/ready buffer.
// Output is suppressed during start-up and after any health failure.
module tt_rng_reader #(
    parameter int WORD_W        = 8,
    parameter int RCT_CUTOFF    = 16,
    parameter int APT_WINDOW    = 64,
    parameter int APT_CUTOFF    = 48,
    parameter int STARTUP_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              rct_fail,
    output logic              apt_fail,
    output logic              health_ok,
    input  logic              clear_fail,
    output logic [7:0]        drop_cnt
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int AI_W = $clog2(APT_WINDOW);
    localparam int AC_W = $clog2(APT_WINDOW + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
    localparam logic [7:0]      RCT_CUT = 8'(RCT_CUTOFF);
    localparam logic [AC_W-1:0] APT_CUT = AC_W'(APT_CUTOFF);
    localparam logic [3:0]      SU_LAST = 4'(STARTUP_WORDS - 1);

    typedef enum logic [1:0] {
        S_STARTUP = 2'd0,
        S_RUN     = 2'd1,
        S_FAIL    = 2'd2
    } state_t;

    state_t            state_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [WORD_W-1:0] pack_q;
    logic [7:0]        run_q;
    logic              prev_q;
    logic              rct_first_q;
    logic [AI_W-1:0]   apt_idx_q;
    logic [AC_W-1:0]   apt_cnt_q;
    logic              apt_ref_q;
    logic [3:0]        start_cnt_q;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic              rct_fail_q;
    logic              apt_fail_q;
    logic              health_ok_q;
    logic [7:0]        drop_cnt_q;

    logic              accept;
    logic              word_done;
    logic              rct_hit;
    logic              apt_hit;
    logic [7:0]        run_d;
    logic [AC_W-1:0]   apt_cnt_d;
    logic              apt_ref_d;
    logic [AI_W-1:0]   apt_idx_d;
    logic [WORD_W-1:0] pack_d;

    // Health-test and packing results for the bit offered this cycle
    always_comb begin
        accept    = bit_valid && (state_q != S_FAIL);
        run_d     = (rct_first_q || (bit_in != prev_q)) ? 8'd1 : run_q + 8'd1;
        apt_idx_d = apt_idx_q + AI_W'(1);
        if (apt_idx_q == '0) begin
            apt_ref_d = bit_in;
            apt_cnt_d = AC_W'(1);
        end else begin
            apt_ref_d = apt_ref_q;
            apt_cnt_d = apt_cnt_q + AC_W'(bit_in == apt_ref_q);
        end
        pack_d            = pack_q;
        pack_d[bit_cnt_q] = bit_in;
        word_done = accept && (bit_cnt_q == BC_LAST);
        rct_hit   = accept && (run_d == RCT_CUT);
        apt_hit   = accept && (apt_cnt_d == APT_CUT);
    end

    // Control FSM with all state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_STARTUP;
            bit_cnt_q    <= '0;
            pack_q       <= '0;
            run_q        <= '0;
            prev_q       <= 1'b0;
            rct_first_q  <= 1'b1;
            apt_idx_q    <= '0;
            apt_cnt_q    <= '0;
            apt_ref_q    <= 1'b0;
            start_cnt_q  <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            rct_fail_q   <= 1'b0;
            apt_fail_q   <= 1'b0;
            health_ok_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else if (state_q == S_FAIL) begin
            // Bits are ignored here, even one arriving with clear_fail
            if (clear_fail) begin
                state_q     <= S_STARTUP;
                rct_fail_q  <= 1'b0;
                apt_fail_q  <= 1'b0;
                bit_cnt_q   <= '0;
                pack_q      <= '0;
                run_q       <= '0;
                rct_first_q <= 1'b1;
                apt_idx_q   <= '0;
                apt_cnt_q   <= '0;
                start_cnt_q <= '0;
            end
        end else if (rct_hit || apt_hit) begin
            // Failure: flush buffered and partial words; a flushed word is not a drop
            state_q      <= S_FAIL;
            rct_fail_q   <= rct_hit;
            apt_fail_q   <= apt_hit;
            health_ok_q  <= 1'b0;
            word_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            pack_q       <= '0;
        end else begin
            if (accept) begin
                run_q       <= run_d;
                prev_q      <= bit_in;
                rct_first_q <= 1'b0;
                apt_idx_q   <= apt_idx_d;
                apt_cnt_q   <= apt_cnt_d;
                apt_ref_q   <= apt_ref_d;
                if (word_done) begin
                    bit_cnt_q <= '0;
                    pack_q    <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                    pack_q    <= pack_d;
                end
            end
            if (word_done && (state_q == S_RUN)) begin
                if (!word_valid_q || word_ready) begin
                    word_q       <= pack_d;
                    word_valid_q <= 1'b1;
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end else if (word_valid_q && word_ready) begin
                word_valid_q <= 1'b0;
            end
            if (word_done && (state_q == S_STARTUP)) begin
                if (start_cnt_q == SU_LAST) begin
                    state_q     <= S_RUN;
                    health_ok_q <= 1'b1;
                end else begin
                    start_cnt_q <= start_cnt_q + 4'd1;
                end
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign rct_fail   = rct_fail_q;
    assign apt_fail   = apt_fail_q;
    assign health_ok  = health_ok_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_tt_rng_reader.sv
// tb_tt_rng_reader: directed stimulus with a queue-based reference model and literal spot checks.
module tb_tt_rng_reader;

    localparam int WORD_W        = 8;
    localparam int RCT_CUTOFF    = 16;
    localparam int APT_WINDOW    = 64;
    localparam int APT_CUTOFF    = 48;
    localparam int STARTUP_WORDS = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              word_ready = 1'b0;
    logic              clear_fail = 1'b0;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              rct_fail;
    logic              apt_fail;
    logic              health_ok;
    logic [7:0]        drop_cnt;

    tt_rng_reader #(
        .WORD_W(WORD_W), .RCT_CUTOFF(RCT_CUTOFF), .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF), .STARTUP_WORDS(STARTUP_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .rct_fail(rct_fail), .apt_fail(apt_fail), .health_ok(health_ok),
        .clear_fail(clear_fail), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: mode 0 start-up, 1 run, 2 fail
    int                m_mode;
    bit                m_valid;
    logic [WORD_W-1:0] m_word;
    bit                m_rct, m_apt, m_health;
    int                m_drop;
    bit                hist[$];
    bit                win[$];
    bit                wbits[$];
    int                words_done;

    task automatic mreset();
        m_mode = 0; m_valid = 0; m_word = '0; m_rct = 0; m_apt = 0;
        m_health = 0; m_drop = 0; words_done = 0;
        hist.delete(); win.delete(); wbits.delete();
    endtask

    task automatic mstep(input bit b, input bit bv, input bit rdy, input bit clr);
        int run, cnt;
        bit done;
        logic [WORD_W-1:0] w;
        done = 0;
        w = '0;
        if (m_mode == 2) begin
            if (clr) begin
                m_rct = 0; m_apt = 0; words_done = 0; m_mode = 0;
                hist.delete(); win.delete(); wbits.delete();
            end
            return;
        end
        if (bv) begin
            hist.push_back(b);
            if (hist.size() > RCT_CUTOFF) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] == b) run++;
                else break;
            end
            if (win.size() == APT_WINDOW) win.delete();
            win.push_back(b);
            cnt = 0;
            foreach (win[i]) if (win[i] == win[0]) cnt++;
            if (run == RCT_CUTOFF || cnt == APT_CUTOFF) begin
                m_rct = (run == RCT_CUTOFF);
                m_apt = (cnt == APT_CUTOFF);
                m_mode = 2; m_health = 0; m_valid = 0;
                wbits.delete();
                return;
            end
            wbits.push_back(b);
            if (wbits.size() == WORD_W) begin
                foreach (wbits[i]) w[i] = wbits[i];
                wbits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_mode == 1) begin
                if (!m_valid || rdy) begin
                    m_word = w; m_valid = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else begin
                words_done++;
                if (words_done == STARTUP_WORDS) begin
                    m_mode = 1; m_health = 1;
                end
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // Advance the model on each clock edge out of reset
    always @(posedge clk) if (rst_n === 1'b1) mstep(bit_in, bit_valid, word_ready, clear_fail);

    always @(negedge rst_n) mreset();

    // Compare every DUT output against the model on the inactive edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("word_valid", word_valid, m_valid);
            if (m_valid) chk("word_out", word_out, m_word);
            chk("rct_fail", rct_fail, m_rct);
            chk("apt_fail", apt_fail, m_apt);
            chk("health_ok", health_ok, m_health);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic cyc(input logic b, input logic bv, input logic rdy, input logic clr);
        bit_in = b; bit_valid = bv; word_ready = rdy; clear_fail = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_byte(input logic [7:0] v, input logic rdy);
        for (int i = 0; i < 8; i++) cyc(v[i], 1'b1, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        rst_n = 1'b0;
        mreset();
        cmp_en = 1;
        repeat (2) cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Reset in the middle of a word
        cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
        rst_n = 1'b0;
        cyc(0, 0, 1, 0);
        chk("rst word_valid", word_valid, 0);
        chk("rst rct_fail", rct_fail, 0);
        chk("rst apt_fail", apt_fail, 0);
        chk("rst health_ok", health_ok, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        cyc(0, 0, 1, 0);

        // Start-up: four 0x55 words discarded, then 0x5A presented
        for (int w = 0; w < 4; w++) begin
            feed_byte(8'h55, 1'b1);
            if (w < 3) chk("startup no health", health_ok, 0);
        end
        chk("health after bit 32", health_ok, 1);
        chk("model health after bit 32", m_health, 1);
        chk("no word after startup", word_valid, 0);
        feed_byte(8'h5A, 1'b1);
        chk("first word valid", word_valid, 1);
        chk("first word value", word_out, 8'h5A);
        chk("model first word", m_word, 8'h5A);
        cyc(0, 0, 1, 0);
        chk("first word taken", word_valid, 0);

        // Backpressure: first word held, next two dropped
        feed_byte(8'h33, 1'b0);
        feed_byte(8'hA5, 1'b0);
        feed_byte(8'h69, 1'b0);
        chk("held word valid", word_valid, 1);
        chk("held word value", word_out, 8'h33);
        chk("drop count", drop_cnt, 2);
        chk("model drop count", m_drop, 2);
        cyc(0, 0, 1, 0);
        chk("held word taken", word_valid, 0);
        cyc(0, 0, 0, 0);

        // RCT: a run of 15 passes, a run of 16 fails
        for (int i = 0; i < 15; i++) cyc(1, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("run 15 no rct", rct_fail, 0);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1, 0);
        chk("rct_fail set", rct_fail, 1);
        chk("model rct_fail", m_rct, 1);
        chk("rct health low", health_ok, 0);
        chk("rct word_valid low", word_valid, 0);
        chk("rct apt clear", apt_fail, 0);
        for (int i = 0; i < 4; i++) cyc(i[0], 1, 1, 0);

        // Clear together with a bit; bit ignored, 32 more bits of start-up
        cyc(1, 1, 1, 1);
        chk("clear rct", rct_fail, 0);
        chk("clear keeps drops", drop_cnt, 2);
        chk("clear health", health_ok, 0);

        // APT: 48 zeros of reference 0 in groups of three
        for (int k = 1; k <= 63; k++) begin
            cyc((k % 4) == 0, 1, 1, 0);
            if (k == 31) chk("health before bit 32", health_ok, 0);
            if (k == 32) chk("health after clear", health_ok, 1);
            if (k == 62) chk("apt before 48th zero", apt_fail, 0);
        end
        chk("apt_fail set", apt_fail, 1);
        chk("model apt_fail", m_apt, 1);
        chk("apt no rct", rct_fail, 0);
        chk("apt health low", health_ok, 0);
        cyc(0, 0, 1, 1);

        // APT: 47 zeros in a full window does not fail; varied backpressure
        for (int k = 1; k <= 60; k++) cyc((k % 4) == 0, 1, (k % 3) != 0, 0);
        pat = 8'b0000_1100;
        for (int i = 0; i < 4; i++) cyc(pat[i], 1, 1, 0);
        chk("apt 47 no fail", apt_fail, 0);
        chk("apt 47 health", health_ok, 1);
        cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 1, 0); cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1);
        chk("clear ignored in run", health_ok, 1);
        repeat (3) cyc(0, 0, 1, 0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
